scrambler_frame_ctrl: RTL and testbench

SCRAMBLER_FRAME_CTRL -- requirements
Module: scrambler_frame_ctrl

---
 rtl/scrambler_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_scrambler_frame_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scrambler_frame_ctrl.sv
// Serial frame scrambler: a plain sync byte followed by FRAME_BYTES data bytes
// scrambled with a self-synchronising-free additive LFSR (1+x^14+x^15),
// reseeded at every sync byte. One bit per cycle, MSB first.
`timescale 1ns/1ps
module scrambler_frame_ctrl #(
  parameter int unsigned FRAME_BYTES   = 8,
  parameter logic [14:0] SEED          = 15'h4A80,
  parameter bit          SYNC_ERR_HOLD = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  output logic        in_ready,
  output logic        out_valid,
  output logic        out_bit,
  output logic        out_sof,
  output logic [14:0] lfsr_out,
  output logic [7:0]  frame_cnt,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;
  // What the current edge does to the byte pipeline.
  typedef enum logic [2:0] {ACT_NONE, ACT_SHIFT, ACT_SYNC, ACT_DATA, ACT_IDLE, ACT_GAP} act_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);

  state_t     state;
  act_t       act;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;   // data bytes completed in the current frame
  logic [7:0] sh;
  logic       fb, acc, last_bit, last_byte, done, err_n;

  assign fb        = lfsr_out[14] ^ lfsr_out[13];
  assign acc       = in_valid & in_ready;
  assign last_bit  = (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == LAST_IDX);

  // Sync bits go out plain; data bits are XORed with the feedback of the current state.
  assign out_bit = out_valid & (sh[7] ^ ((state == DATA) & fb));

  // Decide the edge action: byte boundaries are the only points where a new byte,
  // an underrun, a frame completion or a protocol error can happen.
  always_comb begin
    act   = ACT_NONE;
    err_n = 1'b0;
    done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) begin
          if (in_sof || !SYNC_ERR_HOLD) act = ACT_SYNC;
          else                          err_n = 1'b1;   // stray byte swallowed
        end
      end
      SYNC, DATA: begin
        if (!last_bit) begin
          act = ACT_SHIFT;
        end else begin
          done = (state == DATA) && last_byte;
          if (done) begin
            // Frame complete: a byte on this edge is judged as if we were already idle.
            if (acc && (in_sof || !SYNC_ERR_HOLD)) begin
              act = ACT_SYNC;
            end else begin
              act   = ACT_IDLE;
              err_n = acc;
            end
          end else if (acc) begin
            act   = in_sof ? ACT_SYNC : ACT_DATA;
            err_n = in_sof;                             // SOF aborts an unfinished frame
          end else begin
            act = ACT_GAP;
          end
        end
      end
      GAP: begin
        if (acc) begin
          act   = in_sof ? ACT_SYNC : ACT_DATA;
          err_n = in_sof;
        end
      end
    endcase
  end

  // Frame FSM, shift register, LFSR and registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 8'd0;
      sh        <= 8'd0;
      lfsr_out  <= SEED;
      frame_cnt <= 8'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err     <= err_n;
      out_sof <= 1'b0;
      // Scrambler only runs while data bits are on the wire.
      if (state == DATA) lfsr_out <= {lfsr_out[13:0], fb};
      if (state == DATA && last_bit) byte_cnt <= done ? 8'd0 : byte_cnt + 8'd1;
      if (done) frame_cnt <= frame_cnt + 8'd1;
      case (act)
        ACT_SHIFT: begin
          sh       <= {sh[6:0], 1'b0};
          bit_cnt  <= bit_cnt + 3'd1;
          in_ready <= (bit_cnt == 3'd6);   // open for the next byte on the last bit
        end
        ACT_SYNC: begin
          state     <= SYNC;
          sh        <= in_data;
          bit_cnt   <= 3'd0;
          byte_cnt  <= 8'd0;
          lfsr_out  <= SEED;
          out_valid <= 1'b1;
          out_sof   <= 1'b1;
          in_ready  <= 1'b0;
        end
        ACT_DATA: begin
          state     <= DATA;
          sh        <= in_data;
          bit_cnt   <= 3'd0;
          out_valid <= 1'b1;
          in_ready  <= 1'b0;
        end
        ACT_IDLE: begin
          state     <= IDLE;
          bit_cnt   <= 3'd0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        ACT_GAP: begin
          state     <= GAP;
          bit_cnt   <= 3'd0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          in_ready <= 1'b1;                // IDLE/GAP hold; first edge after reset opens
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scrambler_frame_ctrl.sv
// Bench for scrambler_frame_ctrl: directed scenarios plus a randomized byte
// stream, checked against a byte-level reference model of the frame rules.
`timescale 1ns/1ps
module tb_scrambler_frame_ctrl;
  localparam int          FB   = 8;
  localparam logic [14:0] SEED = 15'h4A80;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, out_valid, out_bit, out_sof, err;
  logic [14:0] lfsr_out;
  logic [7:0]  frame_cnt;

  scrambler_frame_ctrl #(.FRAME_BYTES(FB), .SEED(SEED), .SYNC_ERR_HOLD(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .in_ready(in_ready), .out_valid(out_valid), .out_bit(out_bit), .out_sof(out_sof),
    .lfsr_out(lfsr_out), .frame_cnt(frame_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  bit          cap_bits[$];
  bit          cap_sof[$];
  logic [14:0] cap_lfsr[$];
  bit          ref_bits[$];
  int err_seen = 0, cur_run = 0, max_run = 0, low_cur = 0, last_low = 0;

  // Capture the serial stream and run lengths mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) begin
        cap_bits.push_back(out_bit);
        cap_sof.push_back(out_sof);
        cap_lfsr.push_back(lfsr_out);
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        if (low_cur > 0) last_low = low_cur;
        low_cur = 0;
      end else begin
        cur_run = 0;
        low_cur++;
      end
      if (err) err_seen++;
    end
  end

  // ---------------- byte-level reference model ----------------
  bit          exp_bits[$];
  bit          exp_sof[$];
  int          exp_err = 0, exp_frames = 0, m_k = 0;
  bit          m_in_frame = 0;
  logic [14:0] m_s = SEED;

  task automatic m_sync(input logic [7:0] d);
    m_s = SEED; m_in_frame = 1; m_k = 0;
    for (int i = 7; i >= 0; i--) begin
      exp_bits.push_back(d[i]);
      exp_sof.push_back(i == 7);
    end
  endtask

  task automatic model_byte(input logic [7:0] d, input bit sof);
    bit f;
    if (!m_in_frame) begin
      if (sof) m_sync(d);
      else exp_err++;
    end else if (sof) begin
      exp_err++;
      m_sync(d);
    end else begin
      for (int i = 7; i >= 0; i--) begin
        f = m_s[14] ^ m_s[13];
        exp_bits.push_back(d[i] ^ f);
        exp_sof.push_back(1'b0);
        m_s = 15'(((m_s << 1) | 15'(f)) & 15'h7FFF);
      end
      m_k++;
      if (m_k == FB) begin
        exp_frames = (exp_frames + 1) % 256;
        m_in_frame = 0;
      end
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit sof);
    int  t = 0;
    bit  rdy;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_sof = sof;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    rdy = in_ready;
    chk("ready_wait", rdy, 1'b1);
    @(posedge clk);
    if (rdy) model_byte(d, sof);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic clear_q();
    cap_bits.delete(); cap_sof.delete(); cap_lfsr.delete();
    exp_bits.delete(); exp_sof.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bit", out_bit, 1'b0);
    chk("rst_out_sof", out_sof, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 8'd0);
    chk("rst_lfsr", lfsr_out, SEED);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("rdy_before_edge", in_ready, 1'b0);
    @(posedge clk); #1 chk("rdy_after_edge", in_ready, 1'b1);
    m_in_frame = 0; exp_frames = 0;
    clear_q();
  endtask

  task automatic cmp_stream(input string tag);
    logic [7:0] g, e, gs, es;
    idle(12);
    chk({tag, "_len"}, cap_bits.size(), exp_bits.size());
    for (int i = 0; i + 8 <= cap_bits.size() && i + 8 <= exp_bits.size(); i += 8) begin
      for (int j = 0; j < 8; j++) begin
        g[7-j] = cap_bits[i+j]; e[7-j] = exp_bits[i+j];
        gs[7-j] = cap_sof[i+j]; es[7-j] = exp_sof[i+j];
      end
      chk($sformatf("%s_byte%0d", tag, i / 8), g, e);
      chk($sformatf("%s_sof%0d", tag, i / 8), gs, es);
    end
    clear_q();
  endtask

  task automatic cmp_ref(input string tag);
    int mism = 0;
    idle(12);
    chk({tag, "_len"}, cap_bits.size(), ref_bits.size());
    for (int i = 0; i < cap_bits.size() && i < ref_bits.size(); i++)
      if (cap_bits[i] != ref_bits[i]) mism++;
    chk({tag, "_bits"}, mism, 0);
  endtask

  logic [7:0] tbl [0:7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    logic [15:0]  g16, s16;
    logic [14:0]  frozen;
    logic [7:0]   fc0;
    int           k;
    tbl = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h80, 8'h3C, 8'hC3};

    // 1: sync 0x47 then data 0x00, bit pattern and LFSR after first data bit
    do_reset();
    send(8'h47, 1'b1);
    send(8'h00, 1'b0);
    idle(10);
    chk("t1_nbits", cap_bits.size(), 16);
    if (cap_bits.size() >= 16) begin
      for (int j = 0; j < 16; j++) begin g16[15-j] = cap_bits[j]; s16[15-j] = cap_sof[j]; end
      chk("t1_bits", g16, 16'h47BF);
      chk("t1_sof", s16, 16'h8000);
      chk("t1_lfsr_d1", cap_lfsr[9], 15'h1501);
    end
    chk("t1_gap_valid", out_valid, 1'b0);

    // 2: full frame streamed continuously
    do_reset();
    max_run = 0;
    send(8'h47, 1'b1);
    for (int i = 0; i < FB; i++) send(tbl[i], 1'b0);
    idle(12);
    chk("t2_run", max_run, 72);
    chk("t2_frame_cnt", frame_cnt, 8'd1);
    chk("t2_idle_valid", out_valid, 1'b0);
    chk("t2_idle_ready", in_ready, 1'b1);
    ref_bits = cap_bits;
    cmp_stream("t2");

    // 3: same frame with a 5-cycle underrun after data byte 3
    send(8'h47, 1'b1);
    for (int i = 0; i < 3; i++) send(tbl[i], 1'b0);
    idle(8);
    frozen = lfsr_out;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t3_gap_valid", out_valid, 1'b0);
      chk("t3_gap_lfsr", lfsr_out, frozen);
    end
    send(tbl[3], 1'b0);
    @(negedge clk); #1;
    chk("t3_gap_len", last_low, 5);
    for (int i = 4; i < FB; i++) send(tbl[i], 1'b0);
    cmp_ref("t3_vs_nogap");
    chk("t3_frame_cnt", frame_cnt, 8'd2);
    cmp_stream("t3");

    // 4: SOF after three data bytes aborts and reseeds
    fc0 = frame_cnt;
    send(8'h47, 1'b1);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    send(8'h47, 1'b1);
    chk("t4_err", err, 1'b1);
    chk("t4_lfsr", lfsr_out, SEED);
    chk("t4_fc_hold", frame_cnt, fc0);
    @(posedge clk); #1 chk("t4_err_pulse", err, 1'b0);
    for (int i = 0; i < FB; i++) send(8'($urandom), 1'b0);
    cmp_stream("t4");
    chk("t4_frame_cnt", frame_cnt, 8'(exp_frames));

    // 5: non-SOF byte in IDLE is dropped with an error
    idle(3);
    max_run = 0;
    send(8'h55, 1'b0);
    chk("t5_err", err, 1'b1);
    idle(10);
    chk("t5_no_valid", max_run, 0);
    chk("t5_ready", in_ready, 1'b1);
    chk("t5_err_count", err_seen, exp_err);

    // 6: reset during data byte 5, then the same frame replays identically
    send(8'h47, 1'b1);
    for (int i = 0; i < 5; i++) send(tbl[i], 1'b0);
    idle(2);
    do_reset();
    chk("t6_no_err", err_seen, exp_err);
    send(8'h47, 1'b1);
    for (int i = 0; i < FB; i++) send(tbl[i], 1'b0);
    cmp_ref("t6_replay");
    chk("t6_frame_cnt", frame_cnt, 8'd1);
    cmp_stream("t6");

    // 7: randomized frames with gaps, stray bytes and mid-frame SOFs
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 3) == 0) send(8'($urandom), 1'b0);
      send(8'($urandom), 1'b1);
      k = 0;
      while (k < FB) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        if ($urandom_range(0, 19) == 0) begin
          send(8'($urandom), 1'b1);
          k = 0;
        end else begin
          send(8'($urandom), 1'b0);
          k++;
        end
      end
      idle($urandom_range(0, 2));
    end
    cmp_stream("rnd");
    chk("rnd_frame_cnt", frame_cnt, 8'(exp_frames));
    chk("rnd_err_count", err_seen, exp_err);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
